// File: rtl/noc_pkg.sv
// Shared NoC definitions: packet field positions, packet/state enums and packet layout.
package noc_pkg;

    localparam int SRC_MSB     = 56;
    localparam int SRC_LSB     = 53;
    localparam int DST_MSB     = 52;
    localparam int DST_LSB     = 49;
    localparam int ROW_MSB     = 48;
    localparam int ROW_LSB     = 46;
    localparam int TYPE_MSB    = 45;
    localparam int TYPE_LSB    = 44;
    localparam int RSVD_MSB    = 43;
    localparam int RSVD_LSB    = 40;
    localparam int PAYLOAD_MSB = 39;
    localparam int PAYLOAD_LSB = 0;

    typedef enum logic [1:0] {
        FILTER = 2'b01,
        IFMAP  = 2'b10,
        PSUM   = 2'b11
    } pkt_type_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        DIST = 2'b10,
        HOLD = 2'b11
    } sched_state_e;

    typedef struct packed {
        logic [3:0]  src;
        logic [3:0]  dst;
        logic [2:0]  row;
        pkt_type_e   ptype;
        logic [3:0]  rsvd;
        logic [39:0] payload;
    } packet_t;

endpackage

// File: rtl/filter_reg_file.sv
// Filter weight storage: one-entry synchronous write, clear-all, and a
// combinational read of one whole row packed as ROW_LEN bytes (entry k in byte k).
module filter_reg_file #(
    parameter int WIDTH_data = 8,
    parameter int DEPTH_F    = 25,
    parameter int ROW_LEN    = 5,
    parameter int AW         = $clog2(DEPTH_F),
    parameter int RW         = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clear,
    input  logic                          we,
    input  logic [AW-1:0]                 waddr,
    input  logic [WIDTH_data-1:0]         wdata,
    input  logic [RW-1:0]                 rsel,
    output logic [ROW_LEN*WIDTH_data-1:0] rdata
);

    localparam int ROWS  = DEPTH_F / ROW_LEN;
    localparam int RBITS = ROW_LEN * WIDTH_data;

    // Flat row-major image: entry e occupies bits [e*WIDTH_data +: WIDTH_data].
    logic [DEPTH_F*WIDTH_data-1:0] mem;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            mem <= '0;
        end else if (we) begin
            for (int e = 0; e < DEPTH_F; e++) begin
                if (int'(waddr) == e) begin
                    mem[e*WIDTH_data +: WIDTH_data] <= wdata;
                end
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (int'(rsel) == r) begin
                rdata = mem[r*RBITS +: RBITS];
            end
        end
    end

endmodule

// File: rtl/filter_dist_sched.sv
// Filter-memory node controller: loads a 5x5 weight filter, then sends one packet per row to PEs.
// Optional saturating out-of-range write counter (err_cnt) enabled by FILTER_SCHED_ERRCNT_EN.
module filter_dist_sched #(
    parameter int WIDTH_addr    = 12,
    parameter int WIDTH_data    = 8,
    parameter int DEPTH_F       = 25,
    parameter int ROW_LEN       = 5,
    parameter int WIDTH_payload = 40,
    parameter int WIDTH_packet  = 57,
    parameter int NODE          = 11,
    parameter int PE_BASE       = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load_start,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [WIDTH_addr-1:0]   wr_addr,
    input  logic [WIDTH_data-1:0]   wr_data,
    input  logic                    load_done,
    input  logic                    dist_req,
    output logic                    pkt_valid,
    input  logic                    pkt_ready,
    output logic [WIDTH_packet-1:0] pkt_data,
    output logic                    busy,
    output logic                    dist_done,
    output logic                    err_addr
`ifdef FILTER_SCHED_ERRCNT_EN
    ,
    output logic [7:0]              err_cnt
`endif
);

    import noc_pkg::*;

    localparam int              ROWS     = DEPTH_F / ROW_LEN;
    localparam int              AW       = $clog2(DEPTH_F);
    localparam logic [2:0]      LAST_ROW = 3'(ROWS - 1);

    sched_state_e             state;
    logic [2:0]               row;
    logic [WIDTH_payload-1:0] row_bytes;
    logic                     wr_fire;
    logic                     addr_oor;
    logic                     store_clear;
    logic                     store_we;

    assign wr_ready  = (state == LOAD);
    assign pkt_valid = (state == DIST);
    assign busy      = (state == LOAD) || (state == DIST);

    assign wr_fire  = wr_valid && wr_ready;
    // Full-width compare so high address bits can never alias into the array.
    assign addr_oor = (wr_addr >= WIDTH_addr'(DEPTH_F));

    // Every state that accepts load_start clears storage on that same edge.
    assign store_clear = load_start && (state != DIST);
    assign store_we    = wr_fire && !addr_oor;

    filter_reg_file #(
        .WIDTH_data (WIDTH_data),
        .DEPTH_F    (DEPTH_F),
        .ROW_LEN    (ROW_LEN),
        .AW         (AW),
        .RW         (3)
    ) u_regs (
        .clk   (clk),
        .reset (reset),
        .clear (store_clear),
        .we    (store_we),
        .waddr (wr_addr[AW-1:0]),
        .wdata (wr_data),
        .rsel  (row),
        .rdata (row_bytes)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            row       <= '0;
            err_addr  <= 1'b0;
            dist_done <= 1'b0;
        end else begin
            err_addr  <= wr_fire && addr_oor;
            dist_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_start) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (load_start) begin
                        state <= LOAD;
                    end else if (load_done) begin
                        state <= DIST;
                        row   <= '0;
                    end
                end
                DIST: begin
                    if (pkt_ready) begin
                        if (row == LAST_ROW) begin
                            state     <= HOLD;
                            row       <= '0;
                            dist_done <= 1'b1;
                        end else begin
                            row <= row + 3'd1;
                        end
                    end
                end
                HOLD: begin
                    if (load_start) begin
                        state <= LOAD;
                    end else if (dist_req) begin
                        state <= DIST;
                        row   <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FILTER_SCHED_ERRCNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt <= '0;
        end else if (wr_fire && addr_oor && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

    // Storage is frozen outside LOAD, so the presented packet is stable under backpressure.
    always_comb begin
        pkt_data                        = '0;
        pkt_data[SRC_MSB:SRC_LSB]       = 4'(NODE);
        pkt_data[DST_MSB:DST_LSB]       = 4'(PE_BASE + int'(row));
        pkt_data[ROW_MSB:ROW_LSB]       = row;
        pkt_data[TYPE_MSB:TYPE_LSB]     = FILTER;
        pkt_data[RSVD_MSB:RSVD_LSB]     = 4'b0000;
        pkt_data[PAYLOAD_MSB:PAYLOAD_LSB] = row_bytes;
    end

endmodule

// File: tb/tb_filter_dist_sched.sv
// Directed bench for filter_dist_sched: load, distribute, backpressure, re-send, reset and restart.
module tb_filter_dist_sched;

    localparam int WA = 12;
    localparam int WD = 8;
    localparam int WP = 57;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          load_start = 1'b0;
    logic          wr_valid = 1'b0;
    logic [WA-1:0] wr_addr = '0;
    logic [WD-1:0] wr_data = '0;
    logic          load_done = 1'b0;
    logic          dist_req = 1'b0;
    logic          pkt_ready = 1'b0;
    logic          wr_ready;
    logic          pkt_valid;
    logic [WP-1:0] pkt_data;
    logic          busy;
    logic          dist_done;
    logic          err_addr;
`ifdef FILTER_SCHED_ERRCNT_EN
    logic [7:0]    err_cnt;
`endif

    int vectors = 0;
    int errors  = 0;
    logic [39:0] exp_pl [5];

    always #5 clk = ~clk;

    filter_dist_sched dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .load_done  (load_done),
        .dist_req   (dist_req),
        .pkt_valid  (pkt_valid),
        .pkt_ready  (pkt_ready),
        .pkt_data   (pkt_data),
        .busy       (busy),
        .dist_done  (dist_done),
        .err_addr   (err_addr)
`ifdef FILTER_SCHED_ERRCNT_EN
        ,
        .err_cnt    (err_cnt)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_pkt(input string tag, input logic [WP-1:0] obs, input logic [WP-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [WP-1:0] exp_pkt(input int r, input logic [39:0] pl);
        return {4'd11, 4'(1 + r), 3'(r), 2'b01, 4'b0000, pl};
    endfunction

    task automatic wr(input int addr, input logic [7:0] data, input logic done);
        wr_valid  = 1'b1;
        wr_addr   = WA'(addr);
        wr_data   = data;
        load_done = done;
        step();
        wr_valid  = 1'b0;
        load_done = 1'b0;
    endtask

    // Expects pkt_ready held high and the DUT presenting row 0 on entry.
    task automatic run_dist(input string tag);
        for (int r = 0; r < 5; r++) begin
            chk_bit({tag, " valid"}, pkt_valid, 1'b1);
            chk_pkt({tag, " row"}, pkt_data, exp_pkt(r, exp_pl[r]));
            chk_bit({tag, " early done"}, dist_done, 1'b0);
            step();
        end
        chk_bit({tag, " dist_done"}, dist_done, 1'b1);
        chk_bit({tag, " valid drop"}, pkt_valid, 1'b0);
        step();
        chk_bit({tag, " done pulse"}, dist_done, 1'b0);
        chk_bit({tag, " hold idle"}, busy, 1'b0);
    endtask

    initial begin
        // Reset state
        step();
        step();
        chk_bit("rst pkt_valid", pkt_valid, 1'b0);
        chk_bit("rst wr_ready", wr_ready, 1'b0);
        chk_bit("rst busy", busy, 1'b0);
        chk_bit("rst dist_done", dist_done, 1'b0);
        chk_bit("rst err_addr", err_addr, 1'b0);
        reset = 1'b0;

        // IDLE ignores dist_req
        dist_req = 1'b1;
        step();
        dist_req = 1'b0;
        chk_bit("idle dist_req", pkt_valid, 1'b0);

        // Nominal load of entries 0..24, last write coincides with load_done
        pkt_ready  = 1'b1;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        chk_bit("load wr_ready", wr_ready, 1'b1);
        chk_bit("load busy", busy, 1'b1);
        for (int i = 0; i < 25; i++) begin
            wr(i, 8'(i), (i == 24));
        end
        exp_pl[0] = 40'h0403020100;
        exp_pl[1] = 40'h0908070605;
        exp_pl[2] = 40'h0E0D0C0B0A;
        exp_pl[3] = 40'h131211100F;
        exp_pl[4] = 40'h1817161514;
        chk_bit("nom wr_ready off", wr_ready, 1'b0);
        run_dist("nom");

        // Re-send with backpressure on row 2; dist_req/load_start/wr_valid ignored in DIST
        pkt_ready = 1'b0;
        dist_req  = 1'b1;
        step();
        dist_req = 1'b0;
        chk_pkt("bp row0 stalled", pkt_data, exp_pkt(0, exp_pl[0]));
        pkt_ready = 1'b1;
        step();
        chk_pkt("bp row1", pkt_data, exp_pkt(1, exp_pl[1]));
        step();
        pkt_ready  = 1'b0;
        dist_req   = 1'b1;
        load_start = 1'b1;
        wr_valid   = 1'b1;
        wr_addr    = 12'd10;
        wr_data    = 8'hEE;
        for (int c = 0; c < 3; c++) begin
            chk_bit("bp valid", pkt_valid, 1'b1);
            chk_pkt("bp row2 stable", pkt_data, exp_pkt(2, exp_pl[2]));
            chk_bit("bp wr_ready", wr_ready, 1'b0);
            step();
        end
        dist_req   = 1'b0;
        load_start = 1'b0;
        wr_valid   = 1'b0;
        chk_pkt("bp row2 last", pkt_data, exp_pkt(2, exp_pl[2]));
        pkt_ready = 1'b1;
        step();
        chk_pkt("bp row3", pkt_data, exp_pkt(3, exp_pl[3]));
        step();
        chk_pkt("bp row4", pkt_data, exp_pkt(4, exp_pl[4]));
        step();
        chk_bit("bp dist_done", dist_done, 1'b1);
        chk_bit("bp valid drop", pkt_valid, 1'b0);
        step();
        chk_bit("bp no restart", pkt_valid, 1'b0);
        chk_bit("bp no load", wr_ready, 1'b0);

        // Sparse, restart, out-of-range and duplicate writes
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        wr(0, 8'hFF, 1'b0);
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        wr(7, 8'hAA, 1'b0);
        chk_bit("sparse no err", err_addr, 1'b0);
        wr(30, 8'h55, 1'b0);
        chk_bit("sparse err pulse", err_addr, 1'b1);
        wr(3, 8'h11, 1'b0);
        chk_bit("sparse err clear", err_addr, 1'b0);
        wr(3, 8'h22, 1'b0);
        load_done = 1'b1;
        step();
        load_done = 1'b0;
        exp_pl[0] = 40'h0022000000;
        exp_pl[1] = 40'h0000AA0000;
        exp_pl[2] = 40'h0;
        exp_pl[3] = 40'h0;
        exp_pl[4] = 40'h0;
        run_dist("sparse");

        // load_start and dist_req together in HOLD: load wins
        load_start = 1'b1;
        dist_req   = 1'b1;
        step();
        load_start = 1'b0;
        dist_req   = 1'b0;
        chk_bit("collide wr_ready", wr_ready, 1'b1);
        chk_bit("collide no pkt", pkt_valid, 1'b0);
        wr(24, 8'h5A, 1'b1);
        exp_pl[0] = 40'h0;
        exp_pl[1] = 40'h0;
        exp_pl[4] = 40'h5A00000000;
        run_dist("collide");

        // Reset while row 3 is pending
        dist_req = 1'b1;
        step();
        dist_req = 1'b0;
        step();
        step();
        step();
        pkt_ready = 1'b0;
        chk_pkt("pre-reset row3", pkt_data, exp_pkt(3, exp_pl[3]));
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_bit("mid reset valid", pkt_valid, 1'b0);
        chk_bit("mid reset busy", busy, 1'b0);
        dist_req = 1'b1;
        step();
        dist_req = 1'b0;
        chk_bit("post reset idle", pkt_valid, 1'b0);

        // New session after reset: only entry 12 written
        pkt_ready  = 1'b1;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        wr(12, 8'h77, 1'b1);
        exp_pl[2] = 40'h0000770000;
        exp_pl[4] = 40'h0;
        run_dist("restart");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
